// File: rtl/timer_pkg.sv
// Shared constants and types for the MMIO timer slot: bus widths, register map, bit positions.
package timer_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_CNT_LO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_CNT_HI = 5'd1;
    localparam logic [ADDR_W-1:0] REG_CTRL   = 5'd2;
    localparam logic [ADDR_W-1:0] REG_CMP_LO = 5'd3;
    localparam logic [ADDR_W-1:0] REG_CMP_HI = 5'd4;
    localparam logic [ADDR_W-1:0] REG_STATUS = 5'd5;

    localparam int unsigned CTRL_GO          = 0;
    localparam int unsigned CTRL_CLEAR       = 1;
    localparam int unsigned CTRL_AUTO_RELOAD = 2;
    localparam int unsigned CTRL_IRQ_EN      = 3;

    localparam int unsigned ST_MATCH = 0;
    localparam int unsigned ST_OVF   = 1;

    // Persistent CTRL state; the clear bit is a pulse and is never stored.
    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic go;
    } ctrl_t;

endpackage

// File: rtl/mmio_timer_core_if.sv
// Basic-bus slot signals between the MMIO controller (master) and the timer responder (slave).
interface mmio_timer_core_if;
    import timer_pkg::*;

    logic              cs;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              irq;

    modport master (output cs, read, write, addr, wr_data, input rd_data, irq);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data, irq);

endinterface

// File: rtl/timer_counter.sv
// Free-running counter with compare match, auto-reload, overflow detect and W1C flag registers.
module timer_counter #(
    parameter int unsigned CNT_W = 48
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_go,
    input  logic             i_auto_reload,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_cmp,
    input  logic             i_w1c_match,
    input  logic             i_w1c_ovf,
    output logic [CNT_W-1:0] o_count,
    output logic             o_match_flag,
    output logic             o_ovf_flag
);

    logic [CNT_W-1:0] r_count;
    logic             r_match_flag;
    logic             r_ovf_flag;
    logic             w_match;
    logic             w_reload;
    logic             w_ovf;

    // Overflow only counts a genuine wrap, not a cycle where reload or clear takes over.
    always_comb begin
        w_match  = i_go && (r_count == i_cmp);
        w_reload = w_match && i_auto_reload;
        w_ovf    = i_go && (&r_count) && !w_reload && !i_clear;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count      <= '0;
            r_match_flag <= 1'b0;
            r_ovf_flag   <= 1'b0;
        end else begin
            if (i_clear) begin
                r_count <= '0;
            end else if (w_reload) begin
                r_count <= '0;
            end else if (i_go) begin
                r_count <= r_count + CNT_W'(1);
            end
            // A set in the same cycle as a W1C wins.
            r_match_flag <= (r_match_flag & ~i_w1c_match) | w_match;
            r_ovf_flag   <= (r_ovf_flag & ~i_w1c_ovf) | w_ovf;
        end
    end

    assign o_count      = r_count;
    assign o_match_flag = r_match_flag;
    assign o_ovf_flag   = r_ovf_flag;

endmodule

// File: rtl/mmio_timer_core.sv
// MMIO timer responder: bus decode, register file, snapshot for atomic wide reads, same-cycle read mux.
module mmio_timer_core
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 48
) (
    input  logic               clk,
    input  logic               reset_n,
    mmio_timer_core_if.slave   bus
);

    localparam int unsigned HI_W = CNT_W - 32;

    ctrl_t             r_ctrl;
    logic [CNT_W-1:0]  r_cmp;
    logic [HI_W-1:0]   r_snap_hi;

    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_wr_ctrl;
    logic              w_wr_cmp_lo;
    logic              w_wr_cmp_hi;
    logic              w_wr_status;
    logic              w_rd_cnt_lo;
    logic              w_clear;
    logic              w_w1c_match;
    logic              w_w1c_ovf;
    logic [CNT_W-1:0]  w_count;
    logic              w_match_flag;
    logic              w_ovf_flag;
    logic [DATA_W-1:0] w_rd_data;

    always_comb begin
        w_wr_en      = bus.cs && bus.write;
        w_rd_en      = bus.cs && bus.read;
        w_wr_ctrl    = w_wr_en && (bus.addr == REG_CTRL);
        w_wr_cmp_lo  = w_wr_en && (bus.addr == REG_CMP_LO);
        w_wr_cmp_hi  = w_wr_en && (bus.addr == REG_CMP_HI);
        w_wr_status  = w_wr_en && (bus.addr == REG_STATUS);
        w_rd_cnt_lo  = w_rd_en && (bus.addr == REG_CNT_LO);
        w_clear      = w_wr_ctrl && bus.wr_data[CTRL_CLEAR];
        w_w1c_match  = w_wr_status && bus.wr_data[ST_MATCH];
        w_w1c_ovf    = w_wr_status && bus.wr_data[ST_OVF];
    end

    // Register file; a CNT_LO read freezes the upper counter bits for the following CNT_HI read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ctrl    <= '0;
            r_cmp     <= '1;
            r_snap_hi <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl.go          <= bus.wr_data[CTRL_GO];
                r_ctrl.auto_reload <= bus.wr_data[CTRL_AUTO_RELOAD];
                r_ctrl.irq_en      <= bus.wr_data[CTRL_IRQ_EN];
            end
            if (w_wr_cmp_lo) begin
                r_cmp[31:0] <= bus.wr_data;
            end
            if (w_wr_cmp_hi) begin
                r_cmp[CNT_W-1:32] <= bus.wr_data[HI_W-1:0];
            end
            if (w_rd_cnt_lo) begin
                r_snap_hi <= w_count[CNT_W-1:32];
            end
        end
    end

    timer_counter #(.CNT_W(CNT_W)) u_counter (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_go          (r_ctrl.go),
        .i_auto_reload (r_ctrl.auto_reload),
        .i_clear       (w_clear),
        .i_cmp         (r_cmp),
        .i_w1c_match   (w_w1c_match),
        .i_w1c_ovf     (w_w1c_ovf),
        .o_count       (w_count),
        .o_match_flag  (w_match_flag),
        .o_ovf_flag    (w_ovf_flag)
    );

    // Read mux reflects pre-write state, so a simultaneous write never shows through.
    always_comb begin
        w_rd_data = '0;
        if (w_rd_en) begin
            case (bus.addr)
                REG_CNT_LO: w_rd_data = w_count[31:0];
                REG_CNT_HI: w_rd_data = DATA_W'(r_snap_hi);
                REG_CTRL:   w_rd_data = DATA_W'({r_ctrl.irq_en, r_ctrl.auto_reload, 1'b0, r_ctrl.go});
                REG_CMP_LO: w_rd_data = r_cmp[31:0];
                REG_CMP_HI: w_rd_data = DATA_W'(r_cmp[CNT_W-1:32]);
                REG_STATUS: w_rd_data = DATA_W'({w_ovf_flag, w_match_flag});
                default:    w_rd_data = '0;
            endcase
        end
    end

    assign bus.rd_data = w_rd_data;
    assign bus.irq     = r_ctrl.irq_en & w_match_flag;

endmodule

// File: tb/tb_mmio_timer_core.sv
// Self-checking bench for mmio_timer_core: randomized scenarios against expectations derived from the register rules.
module tb_mmio_timer_core;

    localparam int unsigned CNT_W = 48;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;
    logic [CNT_W-1:0] r_force_val;

    mmio_timer_core_if bus_if();

    mmio_timer_core #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus_if.cs      = 1'b1;
        bus_if.write   = 1'b1;
        bus_if.addr    = a;
        bus_if.wr_data = d;
        cycle();
        bus_if.cs      = 1'b0;
        bus_if.write   = 1'b0;
        bus_if.wr_data = '0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        bus_if.cs   = 1'b1;
        bus_if.read = 1'b1;
        bus_if.addr = a;
        #1;
        d = bus_if.rd_data;
        cycle();
        bus_if.cs   = 1'b0;
        bus_if.read = 1'b0;
    endtask

    // Place the counter at an arbitrary value while stopped; the held value is captured across one edge.
    task automatic preload(input logic [CNT_W-1:0] v);
        r_force_val = v;
        force dut.u_counter.r_count = r_force_val;
        cycle();
        release dut.u_counter.r_count;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp;
        reset_n = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;
        n_checks++;
        if (bus_if.irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", bus_if.irq);
        else n_pass++;
        n_checks++;
        if (bus_if.rd_data !== 32'h0) $display("FAIL reset_rd_idle: got %h expected 0", bus_if.rd_data);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp = (i == 3) ? 32'hFFFF_FFFF : (i == 4) ? 32'h0000_FFFF : 32'h0;
            bus_read(5'(i), d);
            n_checks++;
            if (d !== exp) $display("FAIL reset_reg%0d: got %h expected %h", i, d, exp);
            else n_pass++;
        end
    endtask

    task automatic test_regs();
        logic [31:0] c, lo, hi, junk, d;
        logic [4:0]  ja;
        for (int it = 0; it < 4; it++) begin
            c    = $urandom & 32'hE;
            lo   = $urandom;
            hi   = $urandom;
            junk = $urandom;
            ja   = 5'($urandom_range(6, 31));
            bus_write(5'd2, c);
            bus_write(5'd3, lo);
            bus_write(5'd4, hi);
            bus_write(ja, junk);
            bus_read(5'd2, d);
            n_checks++;
            if (d !== (c & 32'hC)) $display("FAIL regs_ctrl: got %h expected %h", d, c & 32'hC);
            else n_pass++;
            bus_read(5'd3, d);
            n_checks++;
            if (d !== lo) $display("FAIL regs_cmp_lo: got %h expected %h", d, lo);
            else n_pass++;
            bus_read(5'd4, d);
            n_checks++;
            if (d !== (hi & 32'hFFFF)) $display("FAIL regs_cmp_hi: got %h expected %h", d, hi & 32'hFFFF);
            else n_pass++;
            bus_read(ja, d);
            n_checks++;
            if (d !== 32'h0) $display("FAIL regs_unmapped%0d: got %h expected 0", ja, d);
            else n_pass++;
        end
        bus_if.cs   = 1'b0;
        bus_if.read = 1'b1;
        bus_if.addr = 5'd3;
        #1;
        n_checks++;
        if (bus_if.rd_data !== 32'h0) $display("FAIL regs_cs_low: got %h expected 0", bus_if.rd_data);
        else n_pass++;
        bus_if.read = 1'b0;
        cycle();
    endtask

    task automatic test_rw_collision();
        logic [31:0] a, b, d;
        a = $urandom;
        b = ~a;
        bus_write(5'd3, a);
        bus_if.cs      = 1'b1;
        bus_if.read    = 1'b1;
        bus_if.write   = 1'b1;
        bus_if.addr    = 5'd3;
        bus_if.wr_data = b;
        #1;
        d = bus_if.rd_data;
        cycle();
        bus_if.cs    = 1'b0;
        bus_if.read  = 1'b0;
        bus_if.write = 1'b0;
        n_checks++;
        if (d !== a) $display("FAIL rw_pre_write: got %h expected %h", d, a);
        else n_pass++;
        bus_read(5'd3, d);
        n_checks++;
        if (d !== b) $display("FAIL rw_post_write: got %h expected %h", d, b);
        else n_pass++;
    endtask

    task automatic test_free_run();
        logic [31:0] d;
        int n;
        n = $urandom_range(20, 150);
        bus_write(5'd2, 32'h2);
        bus_write(5'd2, 32'h1);
        repeat (n) cycle();
        bus_write(5'd2, 32'h0);
        // go is live from the edge after it is written up to and including the edge that stops it
        for (int k = 0; k < 2; k++) begin
            bus_read(5'd0, d);
            n_checks++;
            if (d !== 32'(n + 1)) $display("FAIL free_run_lo%0d: got %0d expected %0d", k, d, n + 1);
            else n_pass++;
        end
        bus_read(5'd1, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL free_run_hi: got %h expected 0", d);
        else n_pass++;
    endtask

    task automatic test_auto_reload();
        int k;
        k = $urandom_range(3, 12);
        bus_write(5'd2, 32'h2);
        bus_write(5'd3, 32'(k));
        bus_write(5'd4, 32'h0);
        bus_write(5'd5, 32'h3);
        bus_write(5'd2, 32'hD);
        // Counter reaches k after k edges; the flag appears one edge later, every k+1 edges.
        for (int i = 1; i <= k + 1; i++) begin
            cycle();
            n_checks++;
            if (bus_if.irq !== (i == k + 1)) $display("FAIL reload_first i=%0d: got %b expected %b", i, bus_if.irq, i == k + 1);
            else n_pass++;
        end
        bus_write(5'd5, 32'h1);
        n_checks++;
        if (bus_if.irq !== 1'b0) $display("FAIL reload_w1c: got %b expected 0", bus_if.irq);
        else n_pass++;
        for (int j = k + 3; j <= 2 * k + 2; j++) begin
            cycle();
            n_checks++;
            if (bus_if.irq !== (j == 2 * k + 2)) $display("FAIL reload_second j=%0d: got %b expected %b", j, bus_if.irq, j == 2 * k + 2);
            else n_pass++;
        end
        repeat (k) cycle();
        bus_write(5'd5, 32'h1);
        n_checks++;
        if (bus_if.irq !== 1'b1) $display("FAIL reload_set_wins: got %b expected 1", bus_if.irq);
        else n_pass++;
        bus_write(5'd2, 32'h2);
    endtask

    task automatic test_atomic();
        logic [31:0] d;
        int dd;
        dd = $urandom_range(0, 5);
        bus_write(5'd2, 32'h0);
        preload(48'h0000_FFFF_FFFF - CNT_W'(dd));
        bus_write(5'd2, 32'h1);
        repeat (dd) cycle();
        bus_read(5'd0, d);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) $display("FAIL atomic_lo: got %h expected ffffffff", d);
        else n_pass++;
        cycle();
        bus_read(5'd1, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL atomic_hi: got %h expected 0", d);
        else n_pass++;
        bus_write(5'd2, 32'h0);
        bus_read(5'd1, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL atomic_stale_hi: got %h expected 0", d);
        else n_pass++;
        // Four more increments after the LO read carry the count to 0x1_0000_0003.
        bus_read(5'd0, d);
        n_checks++;
        if (d !== 32'h3) $display("FAIL atomic_lo2: got %h expected 3", d);
        else n_pass++;
        bus_read(5'd1, d);
        n_checks++;
        if (d !== 32'h1) $display("FAIL atomic_hi2: got %h expected 1", d);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int dd;
        dd = $urandom_range(0, 5);
        bus_write(5'd2, 32'h0);
        bus_write(5'd3, 32'h5);
        bus_write(5'd4, 32'h0);
        bus_write(5'd5, 32'h3);
        preload({CNT_W{1'b1}} - CNT_W'(dd));
        bus_write(5'd2, 32'h1);
        repeat (dd) cycle();
        bus_read(5'd5, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL ovf_before: got %h expected 0", d);
        else n_pass++;
        bus_read(5'd5, d);
        n_checks++;
        if (d !== 32'h2) $display("FAIL ovf_after: got %h expected 2", d);
        else n_pass++;
        bus_write(5'd2, 32'h0);
        bus_read(5'd0, d);
        n_checks++;
        if (d !== 32'h2) $display("FAIL ovf_wrap_lo: got %h expected 2", d);
        else n_pass++;
        bus_read(5'd1, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL ovf_wrap_hi: got %h expected 0", d);
        else n_pass++;
        bus_write(5'd5, 32'h2);
        bus_read(5'd5, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL ovf_w1c: got %h expected 0", d);
        else n_pass++;
    endtask

    task automatic test_clear_priority();
        logic [31:0] d;
        int k;
        k = $urandom_range(2, 6);
        bus_write(5'd2, 32'h2);
        bus_write(5'd3, 32'(k));
        bus_write(5'd4, 32'h0);
        bus_write(5'd5, 32'h3);
        bus_write(5'd2, 32'h1);
        repeat (k) cycle();
        bus_write(5'd2, 32'h3);
        bus_read(5'd5, d);
        n_checks++;
        if (d !== 32'h1) $display("FAIL clear_match_sets: got %h expected 1", d);
        else n_pass++;
        bus_read(5'd0, d);
        n_checks++;
        if (d !== 32'h1) $display("FAIL clear_wins: got %h expected 1", d);
        else n_pass++;
        n_checks++;
        if (bus_if.irq !== 1'b0) $display("FAIL clear_irq_masked: got %b expected 0", bus_if.irq);
        else n_pass++;
        bus_write(5'd2, 32'h0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [31:0] exp;
        int k;
        int order[6] = '{1, 0, 2, 3, 4, 5};
        k = $urandom_range(3, 8);
        bus_write(5'd2, 32'h0);
        preload(48'h1234_0000_0000);
        bus_read(5'd0, d);
        bus_write(5'd2, 32'h2);
        bus_write(5'd3, 32'(k));
        bus_write(5'd4, 32'h0);
        bus_write(5'd5, 32'h3);
        bus_write(5'd2, 32'hD);
        repeat (k) cycle();
        // Reset lands on the edge where the match flag would otherwise set.
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        n_checks++;
        if (bus_if.irq !== 1'b0) $display("FAIL rstmid_irq: got %b expected 0", bus_if.irq);
        else n_pass++;
        foreach (order[i]) begin
            exp = (order[i] == 3) ? 32'hFFFF_FFFF : (order[i] == 4) ? 32'h0000_FFFF : 32'h0;
            bus_read(5'(order[i]), d);
            n_checks++;
            if (d !== exp) $display("FAIL rstmid_reg%0d: got %h expected %h", order[i], d, exp);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        reset_n        = 1'b0;
        r_force_val    = '0;
        bus_if.cs      = 1'b0;
        bus_if.read    = 1'b0;
        bus_if.write   = 1'b0;
        bus_if.addr    = '0;
        bus_if.wr_data = '0;
        test_reset();
        test_regs();
        test_rw_collision();
        test_free_run();
        test_auto_reload();
        test_atomic();
        test_overflow();
        test_clear_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
